rr_arbiter4: RTL

Four-requester round-robin arbiter that shares one 4:1-selected datapath resource (operand bus or writeback port) between clients. It issues registered one-hot grants and drives the 2-bit select of the shared 4:1 select cell directly. It bounds how long any single client may hold the resource. It sits between the requesting units and the 4:1 select cell, one instance per shared resource.

---
 rtl/rr_arbiter4_pkg.sv | 23 ++
 rtl/rr_pick4.sv | 27 ++
 rtl/rr_arbiter4.sv | 118 +++++++++++
 3 files changed

// File: rtl/rr_arbiter4_pkg.sv
// rtl/rr_arbiter4_pkg.sv - shared types, constants and helpers for the rr_arbiter4 slice
package rr_arbiter4_pkg;

  localparam int NUM_REQ = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // The 4:1 select cell numbers its inputs with the index bits swapped.
  function automatic logic [1:0] sel_encode(input logic [1:0] idx);
    return {idx[0], idx[1]};
  endfunction

  function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [1:0] idx);
    logic [NUM_REQ-1:0] oh;
    oh = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// rtl/rr_pick4.sv - combinational round-robin search over four requests with an exclude mask
module rr_pick4
  import rr_arbiter4_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         ptr,
  input  logic [NUM_REQ-1:0] excl,
  output logic               found,
  output logic [1:0]         winner
);

  // First eligible requester in the order ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  always_comb begin
    logic [1:0] cand;
    found  = 1'b0;
    winner = ptr;
    cand   = ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = ptr + 2'(i);
      if (!found && req[cand] && !excl[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter4.sv
// rtl/rr_arbiter4.sv - four-client round-robin arbiter with bounded hold and registered grants
module rr_arbiter4
  import rr_arbiter4_pkg::*;
#(
  parameter int HOLD_MAX = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic               gnt_valid,
  output logic [1:0]         gnt_idx,
  output logic [1:0]         mux_sel
);

  localparam logic [7:0] HOLD_SAT  = 8'(HOLD_MAX);
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               valid_q, valid_d;
  logic [1:0]         idx_q, idx_d;
  logic [1:0]         mux_q, mux_d;
  logic [1:0]         ptr_q, ptr_d;
  logic [7:0]         hold_q, hold_d;

  logic [NUM_REQ-1:0] excl_mask;
  logic               pick_found;
  logic [1:0]         pick_winner;
  logic               holder_req;

  // While busy the current holder is masked out; on release its request is
  // already low, so the same search serves both release and preemption.
  assign excl_mask  = (state_q == ST_BUSY) ? idx_to_onehot(idx_q) : '0;
  assign holder_req = req[idx_q];

  rr_pick4 u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .excl   (excl_mask),
    .found  (pick_found),
    .winner (pick_winner)
  );

  // Next-state: fresh grant, handover on release, preemption, or hold.
  always_comb begin
    logic grant_new;
    state_d   = state_q;
    gnt_d     = gnt_q;
    valid_d   = valid_q;
    idx_d     = idx_q;
    mux_d     = mux_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    grant_new = 1'b0;

    case (state_q)
      ST_IDLE: begin
        grant_new = pick_found;
      end
      ST_BUSY: begin
        // ">=" rather than "==" so a holder that saturated while uncontended
        // is still handed over as soon as a competitor shows up.
        if ((!holder_req || hold_q >= HOLD_LAST) && pick_found) begin
          grant_new = 1'b1;
        end else if (!holder_req) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
          valid_d = 1'b0;
        end else if (hold_q < HOLD_SAT) begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        valid_d = 1'b0;
      end
    endcase

    if (grant_new) begin
      state_d = ST_BUSY;
      gnt_d   = idx_to_onehot(pick_winner);
      valid_d = 1'b1;
      idx_d   = pick_winner;
      mux_d   = sel_encode(pick_winner);
      ptr_d   = pick_winner + 2'd1;
      hold_d  = 8'd0;
    end
  end

  // State and output registers; reset clears the grant immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      valid_q <= 1'b0;
      idx_q   <= 2'b00;
      mux_q   <= 2'b00;
      ptr_q   <= 2'b00;
      hold_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
      mux_q   <= mux_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = valid_q;
  assign gnt_idx   = idx_q;
  assign mux_sel   = mux_q;

endmodule
